// File: rtl/fp_mul_param_if.sv
// Operand/result handshake bundle for fp_mul_param.
// The slave side is the multiplier; the master side is whoever feeds it.
interface fp_mul_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_z;
  logic [3:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_z, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_z, out_flags
  );
endinterface

// File: rtl/fp_mul_param.sv
// Parametrised IEEE-754 multiplier: multi-cycle FSM, RNE rounding, gradual underflow,
// exception flags {NV, OF, UF, NX}. Fixed latency, one operation in flight.
module fp_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic           clk,
  input logic           rst,
  fp_mul_param_if.slave bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int NW   = PW + 2;
  localparam int LZW  = $clog2(PW + 1);
  // Narrow-exponent formats with wide fractions need extra headroom so the
  // post-normalisation exponent never wraps.
  localparam int EW0  = EXP_W + 3;
  localparam int EW1  = $clog2(PW + 2) + 2;
  localparam int EW   = (EW0 > EW1) ? EW0 : EW1;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, OUT} state_t;
  state_t state, state_nx;

  logic [W-1:0]          a_r, b_r;
  logic                  sign_r;
  logic [MAN_W:0]        ma_r, mb_r;
  logic [EXP_W-1:0]      ea_r, eb_r;
  logic                  byp_r;
  logic [W-1:0]          byp_z_r;
  logic [3:0]            byp_f_r;
  logic [PW-1:0]         prod_r;
  logic signed [EW-1:0]  e_r;
  logic [NW-1:0]         nrm_r;
  logic signed [EW-1:0]  en_r;
  logic                  tiny_r;
  logic [W-1:0]          z_r;
  logic [3:0]            f_r;

  function automatic logic [LZW-1:0] lzc(input logic [PW-1:0] v);
    lzc = LZW'(PW);
    for (int unsigned i = 0; i < PW; i++)
      if (v[i]) lzc = LZW'(PW - 1 - i);
  endfunction

  // ---------------- UNPACK: classification and special-case bypass
  logic [EXP_W-1:0] fa_e, fb_e, ea_u, eb_u;
  logic [MAN_W-1:0] fa_m, fb_m;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic             sign_u, byp_u;
  logic [MAN_W:0]   ma_u, mb_u;
  logic [W-1:0]     byp_z_u;
  logic [3:0]       byp_f_u;

  always_comb begin
    fa_e   = a_r[W-2 -: EXP_W];
    fb_e   = b_r[W-2 -: EXP_W];
    fa_m   = a_r[MAN_W-1:0];
    fb_m   = b_r[MAN_W-1:0];
    a_zero = (fa_e == '0) && (fa_m == '0);
    b_zero = (fb_e == '0) && (fb_m == '0);
    a_inf  = (&fa_e) && (fa_m == '0);
    b_inf  = (&fb_e) && (fb_m == '0);
    a_nan  = (&fa_e) && (fa_m != '0);
    b_nan  = (&fb_e) && (fb_m != '0);
    a_snan = a_nan && !fa_m[MAN_W-1];
    b_snan = b_nan && !fb_m[MAN_W-1];
    sign_u = a_r[W-1] ^ b_r[W-1];
    ma_u   = {(fa_e != '0), fa_m};
    mb_u   = {(fb_e != '0), fb_m};
    ea_u   = (fa_e == '0) ? EXP_W'(1) : fa_e;
    eb_u   = (fb_e == '0) ? EXP_W'(1) : fb_e;

    byp_u   = 1'b0;
    byp_z_u = '0;
    byp_f_u = '0;
    if (a_nan || b_nan) begin
      byp_u   = 1'b1;
      byp_z_u = QNAN;
      byp_f_u = {a_snan || b_snan, 3'b000};
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      byp_u   = 1'b1;
      byp_z_u = QNAN;
      byp_f_u = 4'b1000;
    end else if (a_inf || b_inf) begin
      byp_u   = 1'b1;
      byp_z_u = {sign_u, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      byp_u   = 1'b1;
      byp_z_u = {sign_u, {(W-1){1'b0}}};
    end
  end

  // ---------------- MULT
  logic [PW-1:0]        prod_m;
  logic signed [EW-1:0] e_m;

  always_comb begin
    prod_m = PW'(ma_r) * PW'(mb_r);
    e_m    = EW'(ea_r) + EW'(eb_r) - EW'(BIAS);
  end

  // ---------------- NORM: leading one moved to the MSB, value = 1.f * 2^(e-BIAS);
  // tiny results are denormalised with the shifted-out bits folded into bit 0.
  logic [LZW-1:0]       lz;
  logic [PW-1:0]        shl;
  logic [NW-1:0]        nn, nsh, nrm_n;
  logic signed [EW-1:0] e_n, en_n;
  logic [EW-1:0]        shv;
  logic                 tiny_n, lost;

  always_comb begin
    lz     = lzc(prod_r);
    shl    = prod_r << lz;
    nn     = {shl, 2'b00};
    e_n    = e_r + EW'(1) - EW'(lz);
    tiny_n = e_n[EW-1] || (e_n == '0);
    shv    = EW'(1) - e_n;
    if (shv > EW'(MAN_W + 3)) shv = EW'(MAN_W + 3);
    nsh    = nn >> shv;
    lost   = |(nn & ~({NW{1'b1}} << shv));
    nrm_n  = tiny_n ? {nsh[NW-1:1], nsh[0] | lost} : nn;
    en_n   = tiny_n ? '0 : e_n;
  end

  // ---------------- ROUND (nearest-even)
  logic [MAN_W:0]   m_t;
  logic [MAN_W+1:0] m_rnd;
  logic             g_b, r_b, s_b, inc, nx, of;
  logic [EW-1:0]    exp_f;
  logic [W-1:0]     rz;
  logic [3:0]       rf;

  always_comb begin
    m_t   = nrm_r[NW-1 -: MAN_W+1];
    g_b   = nrm_r[NW-MAN_W-2];
    r_b   = nrm_r[NW-MAN_W-3];
    s_b   = |nrm_r[NW-MAN_W-4:0];
    inc   = g_b && (r_b || s_b || m_t[0]);
    m_rnd = {1'b0, m_t} + (MAN_W+2)'(inc);
    // A subnormal whose hidden bit appears after rounding is the minimum normal.
    if (en_r == '0) exp_f = EW'(m_rnd[MAN_W]);
    else            exp_f = $unsigned(en_r) + EW'(m_rnd[MAN_W+1]);
    nx = g_b || r_b || s_b;
    of = exp_f >= EW'((1 << EXP_W) - 1);
    if (of) begin
      rz = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rf = 4'b0101;
    end else begin
      rz = {sign_r, exp_f[EXP_W-1:0], m_rnd[MAN_W-1:0]};
      rf = {1'b0, 1'b0, tiny_r && nx, nx};
    end
  end

  // ---------------- FSM
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = UNPACK;
      UNPACK:  state_nx = MULT;
      MULT:    state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = OUT;
      OUT:     if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      z_r   <= '0;
      f_r   <= '0;
    end else begin
      state <= state_nx;
      if (state == ROUND) begin
        z_r <= byp_r ? byp_z_r : rz;
        f_r <= byp_r ? byp_f_r : rf;
      end
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (bus.in_valid) begin
        a_r <= bus.in_a;
        b_r <= bus.in_b;
      end
      UNPACK: begin
        sign_r  <= sign_u;
        ma_r    <= ma_u;
        mb_r    <= mb_u;
        ea_r    <= ea_u;
        eb_r    <= eb_u;
        byp_r   <= byp_u;
        byp_z_r <= byp_z_u;
        byp_f_r <= byp_f_u;
      end
      MULT: begin
        prod_r <= prod_m;
        e_r    <= e_m;
      end
      NORM: begin
        nrm_r  <= nrm_n;
        en_r   <= en_n;
        tiny_r <= tiny_n;
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.out_z     = z_r;
  assign bus.out_flags = f_r;
endmodule

// File: tb/tb_fp_mul_param.sv
// Directed bench for fp_mul_param: binary32 and binary16 instances, hand-computed vectors.
module tb_fp_mul_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_mul_param_if #(.EXP_W(8), .MAN_W(23)) bus32 ();
  fp_mul_param_if #(.EXP_W(5), .MAN_W(10)) bus16 ();

  fp_mul_param #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  fp_mul_param #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue32(input string tag, input logic [31:0] a, input logic [31:0] b);
    chk({tag, "_rdy"}, 32'(bus32.in_ready), 32'd1);
    bus32.in_a     = a;
    bus32.in_b     = b;
    bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
  endtask

  task automatic wait_out32(output int n);
    n = 0;
    while (!bus32.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release32(input string tag);
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
    chk({tag, "_idle"}, {31'd0, bus32.in_ready}, 32'd1);
  endtask

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ez, input logic [3:0] ef);
    int n;
    issue32(tag, a, b);
    wait_out32(n);
    chk({tag, "_lat"}, 32'(n), 32'd4);
    chk({tag, "_z"}, bus32.out_z, ez);
    chk({tag, "_flags"}, 32'(bus32.out_flags), 32'(ef));
    release32(tag);
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ez, input logic [3:0] ef);
    int n = 0;
    chk({tag, "_rdy"}, 32'(bus16.in_ready), 32'd1);
    bus16.in_a     = a;
    bus16.in_b     = b;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    while (!bus16.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd4);
    chk({tag, "_z"}, 32'(bus16.out_z), 32'(ez));
    chk({tag, "_flags"}, 32'(bus16.out_flags), 32'(ef));
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(bus16.in_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic seen;

    bus32.in_valid = 1'b1;
    bus32.in_a = 32'h3F800000;
    bus32.in_b = 32'h3F800000;
    bus32.out_ready = 1'b0;
    bus16.in_valid = 1'b0;
    bus16.in_a = '0;
    bus16.in_b = '0;
    bus16.out_ready = 1'b0;

    // reset with in_valid held high: operands must not be taken
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus32.in_valid = 1'b0;
    chk("rst_in_ready", 32'(bus32.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus32.out_valid), 32'd0);
    chk("rst_out_z", bus32.out_z, 32'd0);
    chk("rst_out_flags", 32'(bus32.out_flags), 32'd0);
    @(posedge clk); #1;
    chk("rst_no_accept", 32'(bus32.in_ready), 32'd1);

    op32("mul_1p5x2",  32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
    op32("mul_neg",    32'hBF800000, 32'h40000000, 32'hC0000000, 4'b0000);
    op32("rne_nx",     32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    op32("overflow",   32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101);
    op32("sub_exact",  32'h00800000, 32'h3F000000, 32'h00400000, 4'b0000);
    op32("sub_to_0",   32'h00000001, 32'h3F000000, 32'h00000000, 4'b0011);
    op32("sub_tie",    32'h00000003, 32'h3F000000, 32'h00000002, 4'b0011);
    op32("sub_to_min", 32'h00FFFFFF, 32'h3F000000, 32'h00800000, 4'b0011);
    op32("inf_x_0",    32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    op32("snan",       32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    op32("qnan",       32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000);
    op32("neg_inf",    32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);

    // output back-pressure: result held, new operands refused
    issue32("hs", 32'h3FC00000, 32'h40000000);
    wait_out32(n);
    chk("hs_lat", 32'(n), 32'd4);
    bus32.in_a = 32'h40000000;
    bus32.in_b = 32'h40000000;
    bus32.in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("hs_hold_z", bus32.out_z, 32'h40400000);
      chk("hs_hold_valid", 32'(bus32.out_valid), 32'd1);
      chk("hs_hold_rdy", 32'(bus32.in_ready), 32'd0);
    end
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
    chk("hs_rel_rdy", 32'(bus32.in_ready), 32'd1);
    chk("hs_rel_valid", 32'(bus32.out_valid), 32'd0);
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    chk("hs_accepted", 32'(bus32.in_ready), 32'd0);
    wait_out32(n);
    chk("hs2_lat", 32'(n), 32'd4);
    chk("hs2_z", bus32.out_z, 32'h40800000);
    chk("hs2_flags", 32'(bus32.out_flags), 32'd0);
    release32("hs2");

    // reset while the operation sits in MULT
    issue32("rst_mid", 32'h3FC00000, 32'h40000000);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_rdy", 32'(bus32.in_ready), 32'd1);
    chk("rst_mid_valid", 32'(bus32.out_valid), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | bus32.out_valid;
    end
    chk("rst_mid_no_out", 32'(seen), 32'd0);
    op32("post_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);

    op16("h_one",  16'h3C00, 16'h3C00, 16'h3C00, 4'b0000);
    op16("h_ovf",  16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_mul_param.md
# fp_mul_param

Parametrised IEEE-754 floating-point multiplier with valid/ready handshakes, round-to-nearest-even, gradual underflow and exception flags. Exponent and mantissa widths are generic, so one block covers binary16, binary32 and custom formats. It is the next-generation replacement for the fixed binary32 multiplier in the core datapath. It runs as a multi-cycle FSM with fixed latency and one operation in flight.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- in_a  in  W  operand A
- in_b  in  W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_z  out  W  product
- out_flags  out  4  {NV invalid, OF overflow, UF underflow, NX inexact}

## Operation
- States: IDLE → UNPACK → MULT → NORM → ROUND → OUT → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_a/in_b and go to UNPACK.
- UNPACK: classify each operand as zero, subnormal, normal, inf, qNaN or sNaN.
  - Sign = sa^sb.
  - Subnormal: exponent 1, hidden bit 0. Normal: hidden bit 1.
- MULT: full (MAN_W+1)×(MAN_W+1) product, 2*MAN_W+2 bits.
  - Unbiased sum exponent e = ea+eb−BIAS, with BIAS = 2^(EXP_W−1)−1.
  - Exponent held in EXP_W+3 signed bits; it must never wrap.
- NORM:
  - If the product MSB is set, shift right 1 and increment e.
  - Otherwise leading-zero count in one cycle, shift left, decrement e.
  - If e<1: shift right by (1−e), clamped to MAN_W+3, with all shifted-out bits ORed into sticky; e=0 encodes subnormal.
- ROUND, round-to-nearest-even using guard, round and sticky bits:
  - Increment when G && (R || S || lsb).
  - Mantissa carry-out increments the exponent; a subnormal that rounds up to 2^MAN_W becomes the minimum normal.
  - NX = G||R||S.
  - OF when the final exponent ≥ 2^EXP_W−1: result ±inf, OF=1, NX=1.
  - UF = tiny-before-rounding && NX.
- Special cases are decided in UNPACK, carried through a bypass register, and still take full latency:
  - Any NaN input → canonical qNaN (sign 0, exponent all-ones, fraction MSB 1, rest 0). NV=1 only if either input is an sNaN.
  - inf×0 → canonical qNaN, NV=1.
  - inf×finite-nonzero or inf×inf → ±inf, flags 0.
  - Zero×finite → ±0, flags 0.
- OUT: out_valid=1, and out_z/out_flags are held stable. On out_ready, go to IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, out_z=0, out_flags=0, state=IDLE.
- Operand accept at edge k ⇒ out_valid rises after edge k+4 and holds until the edge where out_valid&&out_ready.
- in_ready=0 from after edge k until the edge completing the output handshake.
- in_ready returns to 1 on the following cycle (IDLE).
- Minimum issue interval is 6 cycles.
- in_a/in_b changes while in_ready=0 are ignored.
- out_ready asserted before out_valid has no effect.
- out_z/out_flags must not change while out_valid=1 && !out_ready.
- rst in any state: return to IDLE and clear all outputs on the same edge. The in-flight operation is discarded and no out_valid is produced for it.
- in_valid asserted together with rst is ignored.

## Test plan
- binary32 basics: 0x3FC00000×0x40000000 → 0x40400000, flags 0, out_valid exactly 4 edges after accept. 0xBF800000×0x40000000 → 0xC0000000.
- RNE and inexact: 0x3F800001×0x3F800001 → 0x3F800002 with NX=1. 0x7F7FFFFF×0x40000000 → 0x7F800000 with OF=1, NX=1.
- Subnormals:
  - 0x00800000×0x3F000000 → 0x00400000, flags 0.
  - 0x00000001×0x3F000000 → 0x00000000 with UF=1, NX=1.
  - 0x00000003×0x3F000000 → 0x00000002 (tie to even), UF=1, NX=1.
- Specials:
  - 0x7F800000×0x00000000 → 0x7FC00000, NV=1.
  - 0x7F800001×0x3F800000 → 0x7FC00000, NV=1.
  - 0x7FC00000×0x3F800000 → 0x7FC00000, NV=0.
  - 0xFF800000×0x40000000 → 0xFF800000.
- Handshake: hold out_ready=0 for 3 cycles after out_valid. out_z stays stable, and in_ready stays 0 despite in_valid=1 with new operands. Release out_ready, then confirm the next operation is accepted one cycle later.
- Reset and generics:
  - Assert rst in the MULT state: out_valid is never raised for that operation and in_ready=1 after the edge.
  - Instance with EXP_W=5, MAN_W=10: 0x3C00×0x3C00 → 0x3C00. 0x7BFF×0x4000 → 0x7C00 with OF=1, NX=1.
